// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-store FIFO sitting after the STD stage. Accepts
//               {address, stored_data} pairs, holds them in order and drains
//               them to the data-memory port over a req/ack handshake.
//               Optional store-to-load forwarding of the youngest matching
//               pending store is enabled by defining STORE_FORWARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    // store side (from STD)
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    // data-memory write port
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    // status
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    // load forwarding lookup
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // entry storage (no reset needed: only occupied slots are ever read)
    logic [ADDR_W-1:0] r_addr_q [DEPTH];
    logic [DATA_W-1:0] r_data_q [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state;
    state_t            w_next_state;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_load;
    logic [ADDR_W-1:0] w_load_addr;
    logic [DATA_W-1:0] w_load_data;
    logic [PTR_W-1:0]  w_head_next;

    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    assign w_full      = (r_count == c_full_count);
    assign w_empty     = (r_count == '0);
    // Readiness depends only on occupancy, so a full buffer refuses a store
    // even in a cycle where the head is being acknowledged.
    assign w_push      = st_valid && !w_full;
    assign w_head_next = r_head + c_ptr_one;

    assign st_ready  = !w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign mem_req   = (r_state == S_REQ);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Capture incoming stores at the tail slot
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_tail] <= st_addr;
            r_data_q[r_tail] <= st_data;
        end
    end

    // Head/tail pointers and occupancy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_ptr_one;
            end
            if (w_pop) begin
                r_head <= w_head_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Drain FSM state register and registered memory-port address/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_mem_addr  <= w_load_addr;
                r_mem_wdata <= w_load_data;
            end
        end
    end

    // Drain FSM next-state: present the head, hold until ack, then chain to
    // the following entry without an idle cycle when one is available
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_load_addr  = '0;
        w_load_data  = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_load       = 1'b1;
                    w_load_addr  = r_addr_q[r_head];
                    w_load_data  = r_data_q[r_head];
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_pop = 1'b1;
                    if (r_count > c_one) begin
                        // next-oldest entry is already in storage
                        w_load      = 1'b1;
                        w_load_addr = r_addr_q[w_head_next];
                        w_load_data = r_data_q[w_head_next];
                    end else if (w_push) begin
                        // only remaining entry is the one arriving now;
                        // it is not in storage yet, so take it from the port
                        w_load      = 1'b1;
                        w_load_addr = st_addr;
                        w_load_data = st_data;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef STORE_FORWARD_EN
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic [PTR_W-1:0]  w_idx;

    // Scan occupied entries oldest to youngest; later matches override, so
    // the result is the youngest pending store to the load address
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_addr_q[w_idx] == ld_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data_q[w_idx];
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;
`else
    // Forwarding disabled: outputs tied off, lookup address intentionally idle
    logic w_unused_ld_addr;
    assign w_unused_ld_addr = ^ld_addr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed self-checking bench for store_buffer: reset state,
//               single store, full buffer, streaming drain, forwarding and
//               asynchronous reset during a drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [2:0]        count;
    logic              empty;
    logic [ADDR_W-1:0] ld_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    int n_tests = 0;
    int n_fail  = 0;

    store_buffer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .count    (count),
        .empty    (empty),
        .ld_addr  (ld_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
    endtask

    logic [DATA_W-1:0] full_data [4];
    logic [DATA_W-1:0] exp_fwd;

    initial begin
        full_data[0] = 20'h11111;
        full_data[1] = 20'h22222;
        full_data[2] = 20'h33333;
        full_data[3] = 20'h44444;

        rst = 1'b1;
        set_store(1'b0, '0, '0);
        mem_ack = 1'b0;
        ld_addr = '0;

        // ---------------- reset state
        tick();
        check("rst_count",  32'(count), 32'd0);
        check("rst_empty",  32'(empty), 32'd1);
        check("rst_ready",  32'(st_ready), 32'd1);
        check("rst_req",    32'(mem_req), 32'd0);
        check("rst_addr",   32'(mem_addr), 32'd0);
        check("rst_wdata",  32'(mem_wdata), 32'd0);
        check("rst_fwd",    32'(fwd_hit), 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- single store, ack held low for 3 cycles
        set_store(1'b1, 10'h001, 20'h12345);
        tick();
        set_store(1'b0, '0, '0);
        check("single_count", 32'(count), 32'd1);
        check("single_req_n", 32'(mem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single_req",   32'(mem_req), 32'd1);
            check("single_addr",  32'(mem_addr), 32'h001);
            check("single_wdata", 32'(mem_wdata), 32'h12345);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("single_done_count", 32'(count), 32'd0);
        check("single_done_req",   32'(mem_req), 32'd0);
        check("single_done_empty", 32'(empty), 32'd1);
        // stray ack with no request must be ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_ack_count", 32'(count), 32'd0);
        check("stray_ack_req",   32'(mem_req), 32'd0);

        // ---------------- fill to full, refuse a fifth store
        for (int i = 0; i < 4; i++) begin
            set_store(1'b1, 10'(10'h010 + i), full_data[i]);
            tick();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(st_ready), 32'd0);
        set_store(1'b1, 10'h3FF, 20'h55555);
        tick();
        check("full_refuse_count", 32'(count), 32'd4);
        // full + ack in same cycle: store still refused
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        set_store(1'b0, '0, '0);
        check("full_ack_count", 32'(count), 32'd3);
        check("full_ack_ready", 32'(st_ready), 32'd1);
        check("full_ack_next",  32'(mem_wdata), 32'(full_data[1]));
        for (int i = 1; i < 4; i++) begin
            check("drain_req",   32'(mem_req), 32'd1);
            check("drain_addr",  32'(mem_addr), 32'(10'h010 + i));
            check("drain_wdata", 32'(mem_wdata), 32'(full_data[i]));
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        check("drain_done_count", 32'(count), 32'd0);
        check("drain_done_req",   32'(mem_req), 32'd0);

        // ---------------- streaming with ack held high
        set_store(1'b1, 10'h020, 20'hA0001); tick();
        set_store(1'b1, 10'h021, 20'hA0002); tick();
        set_store(1'b1, 10'h022, 20'hA0003); tick();
        check("stream_fill", 32'(count), 32'd3);
        check("stream_head", 32'(mem_wdata), 32'hA0001);
        // push + pop together
        set_store(1'b1, 10'h023, 20'hA0004);
        mem_ack = 1'b1;
        tick();
        set_store(1'b0, '0, '0);
        check("stream_pushpop_count", 32'(count), 32'd3);
        check("stream_w2", 32'(mem_wdata), 32'hA0002);
        check("stream_r2", 32'(mem_req), 32'd1);
        tick();
        check("stream_w3", 32'(mem_wdata), 32'hA0003);
        check("stream_c2", 32'(count), 32'd2);
        tick();
        check("stream_w4", 32'(mem_wdata), 32'hA0004);
        check("stream_c1", 32'(count), 32'd1);
        // pop of last entry while a new one arrives: it is presented at once
        set_store(1'b1, 10'h024, 20'hA0005);
        tick();
        set_store(1'b0, '0, '0);
        check("stream_bypass_req",   32'(mem_req), 32'd1);
        check("stream_bypass_addr",  32'(mem_addr), 32'h024);
        check("stream_bypass_wdata", 32'(mem_wdata), 32'hA0005);
        check("stream_bypass_count", 32'(count), 32'd1);
        tick();
        mem_ack = 1'b0;
        check("stream_end_count", 32'(count), 32'd0);
        check("stream_end_req",   32'(mem_req), 32'd0);

        // ---------------- forwarding
        set_store(1'b1, 10'h005, 20'hAAAAA); tick();
        set_store(1'b1, 10'h005, 20'hBBBBB); tick();
        set_store(1'b0, '0, '0);
`ifdef STORE_FORWARD_EN
        exp_fwd = 20'hBBBBB;
`else
        exp_fwd = 20'h00000;
`endif
        ld_addr = 10'h005;
        #1;
        check("fwd_hit_match",  32'(fwd_hit), 32'(exp_fwd != 0));
        check("fwd_data_match", 32'(fwd_data), 32'(exp_fwd));
        ld_addr = 10'h006;
        #1;
        check("fwd_hit_miss",  32'(fwd_hit), 32'd0);
        check("fwd_data_miss", 32'(fwd_data), 32'd0);

        // ---------------- async reset mid-drain (mem_req=1, count=2)
        check("mid_pre_req",   32'(mem_req), 32'd1);
        check("mid_pre_count", 32'(count), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_req",   32'(mem_req), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        #1;
        rst = 1'b0;
        ld_addr = 10'h005;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_req", 32'(mem_req), 32'd0);
        end
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_fwd",   32'(fwd_hit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
# store_buffer

Posted-store queue directly downstream of the STD stage: it accepts the 20-bit `stored_data` word that STD produces, together with its target address, and holds it in a small in-order FIFO. A drain state machine writes entries to the data-memory port over a req/ack handshake, so the pipeline never stalls on memory latency until the queue fills. An optional forwarding path lets a load see the youngest pending store to the same address.

## Interface
- `DATA_W`, 20, store data width; matches STD `stored_data`.
- `ADDR_W`, 10, data-memory word address width.
- `DEPTH`, 4, FIFO entries; must be a power of two, ≥2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `st_valid`  in  1  store request from the STD stage.
- `st_ready`  out  1  buffer can accept; equals `!full`.
- `st_addr`  in  ADDR_W  store address.
- `st_data`  in  DATA_W  store data (STD `stored_data`).
- `mem_req`  out  1  write request to data memory.
- `mem_addr`  out  ADDR_W  write address, registered.
- `mem_wdata`  out  DATA_W  write data, registered.
- `mem_ack`  in  1  memory accepted the write this cycle.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `empty`  out  1  `count == 0`.
- `ld_addr`  in  ADDR_W  load address for forwarding lookup.
- `fwd_hit`  out  1  a pending store matches `ld_addr`.
- `fwd_data`  out  DATA_W  data of youngest matching store.

## Operation
- Push: `st_valid && st_ready` at a rising edge writes {`st_addr`, `st_data`} at the tail; tail pointer increments, wrapping modulo DEPTH.
- `st_ready` depends only on `count`, never on `mem_ack`. When full, a store is refused even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave `count` unchanged.
- Drain FSM, two states:
  - IDLE: `mem_req=0`. If `!empty`, load the head entry into `mem_addr`/`mem_wdata`, set `mem_req=1`, go to REQ.
  - REQ: `mem_req`, `mem_addr` and `mem_wdata` stay stable until `mem_ack`. On `mem_ack`, pop the head.
    - If another entry remains after the pop (including one pushed in the same cycle), load it and stay in REQ.
    - Otherwise drop `mem_req` and go to IDLE.
- `mem_ack` while `mem_req=0` is ignored.
- An entry stays in the FIFO, and visible to forwarding, until its ack edge.
- Entries drain strictly in push order.
- Reset (asynchronous): pointers and `count` go to 0. `mem_req`, `mem_addr`, `mem_wdata`, `fwd_hit`, `fwd_data` go to 0; FSM goes to IDLE. Pending stores are discarded, including one in flight.
- Reset values: `st_ready=1`, `empty=1`, `count=0`.

## Timing
- Store pushed at edge N into an empty, idle buffer: `mem_req=1` after edge N+1.
- Ack sampled at edge M: `count` decrements after M. With more entries pending, the next entry is presented after M (one write per cycle sustained while `mem_ack` stays high).
- Full-to-ready: `st_ready` rises the cycle after the ack edge that frees a slot.
- Forwarding is combinational from `ld_addr` and current buffer contents. It does not see a store being pushed in the same cycle.

## Configuration
- `STORE_FORWARD_EN` defined:
  - Compare `ld_addr` against all occupied entries.
  - `fwd_hit=1` and `fwd_data` = data of the youngest (closest to tail) match.
  - No match: `fwd_hit=0`, `fwd_data=0`.
- Undefined: ports remain; `fwd_hit` and `fwd_data` are tied to 0 and no compare logic is built.

## Test plan
- Reset: assert `rst` → `count=0`, `empty=1`, `st_ready=1`, `mem_req=0`, `mem_addr=0`, `mem_wdata=0`.
- Single store: push addr 0x001, data 0x12345; hold `mem_ack=0` for 3 cycles → `mem_req=1` one cycle after push, addr/data stable; pulse ack → `count=0`, `mem_req=0` next cycle.
- Full: push 0x11111, 0x22222, 0x33333, 0x44444 with `mem_ack=0` → `st_ready=0`, `count=4`; a 5th `st_valid` is not accepted. Then ack four times → memory sees 0x11111…0x44444 in order.
- Streaming: queue 3 stores, hold `mem_ack=1` → three consecutive cycles with `mem_req=1`, one write per cycle. Simultaneous push+pop leaves `count` unchanged.
- Forwarding (`STORE_FORWARD_EN`): push addr 0x005 data 0xAAAAA, then addr 0x005 data 0xBBBBB, no ack. `ld_addr=0x005` → `fwd_hit=1`, `fwd_data=0xBBBBB`; `ld_addr=0x006` → `fwd_hit=0`. Without the macro → `fwd_hit=0` in both cases.
- Reset mid-drain: with `mem_req=1` and `count=2`, assert `rst` asynchronously → `mem_req=0`, `count=0` before the next edge; after release, no write is issued.
